// File: rtl/mac_layer_pkg.sv
// mac_layer_pkg: shared types and helpers for the mac_layer_seq engine.
//   - state_t       : sequencer states (IDLE / ACCUM / DONE)
//   - DEF_*         : default widths and sizes
//   - sat_clip      : clamp a wide signed value into a w-bit signed range
//   - sat_add       : saturating add, used only when MAC_LAYER_SAT_EN is defined
// The saturation helpers work on a SAT_W-bit signed carrier, which covers
// IN_W up to 63 and ACC_W up to 64.
package mac_layer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_OUT = 10;
    localparam int DEF_N_IN  = 32;
    localparam int DEF_IN_W  = 32;
    localparam int DEF_ACC_W = 32;

    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_clip(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one << (w - 1)) - one;
        lo  = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        return sat_clip(a + b, w);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear accumulator (and sticky sat flag)
//   en       : accumulate act*w this cycle
//   act, w   : signed IN_W operands
//   acc      : signed ACC_W accumulator
//   sat      : sticky saturation flag (only with MAC_LAYER_SAT_EN)
// Macro MAC_LAYER_SAT_EN: saturating arithmetic instead of wrap-around.
module mac_lane
    import mac_layer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  act,
    input  logic signed [IN_W-1:0]  w,
    output logic signed [ACC_W-1:0] acc
`ifdef MAC_LAYER_SAT_EN
    ,
    output logic                    sat
`endif
);

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [2*IN_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_next;

    // Operands are sign-extended to the 2*IN_W context before multiplying.
    assign w_prod = act * w;

`ifdef MAC_LAYER_SAT_EN
    logic signed [SAT_W-1:0] w_prod_c;
    logic signed [SAT_W-1:0] w_sum_c;
    logic                    w_ovf;
    logic                    r_sat;

    assign w_prod_c = sat_clip(SAT_W'(w_prod), ACC_W);
    assign w_sum_c  = sat_add(SAT_W'(r_acc), w_prod_c, ACC_W);
    // Either the narrowing or the sum hit a rail.
    assign w_ovf    = (w_prod_c != SAT_W'(w_prod)) ||
                      (w_sum_c != (SAT_W'(r_acc) + w_prod_c));
    assign w_next   = w_sum_c[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_sat <= 1'b0;
        else if (clr)          r_sat <= 1'b0;
        else if (en && w_ovf)  r_sat <= 1'b1;
    end

    assign sat = r_sat;
`else
    // Size cast truncates or sign-extends the product to ACC_W.
    assign w_next = r_acc + ACC_W'(w_prod);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_acc <= '0;
        else if (clr)  r_acc <= '0;
        else if (en)   r_acc <= w_next;
    end

    assign acc = r_acc;

endmodule

// File: rtl/mac_layer_seq.sv
// mac_layer_seq: handshaked fully-connected layer engine.
// One activation per beat is broadcast to N_OUT lanes, each with its own
// weight; after N_IN accepted beats all dot products are offered on p_out.
//   clk, rst            : clock, asynchronous active-high reset
//   start, stop         : restart / abort pulses (stop has priority)
//   in_valid, in_ready  : beat handshake (act_in, w_in)
//   out_valid, out_ready: result handshake (p_out)
//   busy                : state is not IDLE
//   sat_flag            : per-lane sticky saturation (only with MAC_LAYER_SAT_EN)
// Macro MAC_LAYER_SAT_EN: saturating lanes plus the sat_flag port.
module mac_layer_seq
    import mac_layer_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int N_IN  = DEF_N_IN,
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        act_in,
    input  logic [N_OUT*IN_W-1:0]  w_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*ACC_W-1:0] p_out,
    output logic                   busy
`ifdef MAC_LAYER_SAT_EN
    ,
    output logic [N_OUT-1:0]       sat_flag
`endif
);

    localparam int CNT_W = $clog2(N_IN + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_clr;
    logic             w_beat;

    // stop > start > beat; a beat coinciding with either is dropped.
    assign w_clr  = start && !stop;
    assign w_beat = in_valid && r_in_ready && !stop && !start;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
        mac_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (w_clr),
            .en  (w_beat),
            .act (act_in),
            .w   (w_in[gi*IN_W +: IN_W]),
            .acc (p_out[gi*ACC_W +: ACC_W])
`ifdef MAC_LAYER_SAT_EN
            ,
            .sat (sat_flag[gi])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (stop) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (start) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(N_IN - 1)) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/mac_layer_seq.md
Name: mac_layer_seq

Overview:
- Parametrised, handshaked successor to the fixed 10-lane layer-2 MAC array.
- Broadcasts one activation per beat to N_OUT MAC lanes; each lane receives its own weight on the same beat.
- Accumulates exactly N_IN beats, then presents all N_OUT dot products with a valid/ready handshake.
- Serves as a generic fully-connected layer engine between a ReLU stage and the argmax/output stage.

Parameters:
- N_OUT, 10: number of output neurons (MAC lanes); must be ≥1.
- N_IN, 32: beats (inputs per neuron) per dot product; must be ≥1.
- IN_W, 32: signed width of the activation and of each weight.
- ACC_W, 32: signed width of each accumulator and output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; clears all accumulators and begins a new dot product.
- stop  in  1  single-cycle pulse; aborts the current operation and returns to IDLE.
- in_valid  in  1  act_in and w_in are valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- act_in  in  IN_W  signed activation, broadcast to all lanes.
- w_in  in  N_OUT*IN_W  signed weights; lane i occupies bits [i*IN_W +: IN_W].
- out_valid  out  1  p_out holds a completed result.
- out_ready  in  1  consumer accepts the result.
- p_out  out  N_OUT*ACC_W  accumulators; lane i occupies bits [i*ACC_W +: ACC_W].
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, beat counter=0, all accumulators=0, in_ready=0, out_valid=0, busy=0, p_out=0.
- States: IDLE, ACCUM, DONE.
- Beat counter width is $clog2(N_IN+1).
- IDLE:
  - start → ACCUM; accumulators and counter cleared.
  - Otherwise hold; p_out keeps the last result.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready. On acceptance, for each lane i: acc_i <= acc_i + trunc_ACC_W(sext(act_in)*sext(w_i)). The full product is 2*IN_W bits signed, then sign-extended or truncated to ACC_W; addition wraps (two's complement).
  - The counter increments on each accepted beat. On the N_IN-th accepted beat → DONE.
  - out_valid rises the cycle after the final beat (latency 1 cycle from the last accepted beat).
- DONE:
  - out_valid=1, in_ready=0; p_out is stable while out_valid&&!out_ready.
  - out_ready → IDLE; out_valid drops the next cycle.
- Priority each cycle: stop > start > beat/handshake.
  - stop in any state → IDLE; out_valid and in_ready are 0 the next cycle; accumulators are held, not cleared.
  - start in ACCUM or DONE → restart: accumulators and counter are cleared, state=ACCUM, any pending out_valid is dropped.
  - A beat presented in the same cycle as start is not accepted: in_ready is registered, so it is 0 in IDLE.
  - In DONE, start together with out_ready → the restart wins; the result counts as consumed.
- in_valid gaps during ACCUM stall accumulation with no side effects.
- in_valid outside ACCUM is ignored.
- Reset mid-operation discards everything, with no partial output.

Optional Feature:
- Macro: MAC_LAYER_SAT_EN.
- Defined:
  - Each lane's accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation applies to both the product narrowing and the sum.
  - An extra output port sat_flag [N_OUT] is added: a sticky per-lane flag, cleared by start or rst.
- Undefined: wrap-around arithmetic as above; no sat_flag port.

Decomposition:
- Package mac_layer_pkg:
  - State enum (IDLE/ACCUM/DONE).
  - Default widths.
  - Function sat_add(a,b) used when MAC_LAYER_SAT_EN is defined.
- Sub-module mac_lane (one per output; generate loop):
  - Inputs: clk, rst, clr, en, act, w.
  - Outputs: acc, plus sat under the macro.
- The top level holds the FSM, the beat counter and the handshake.

Test Plan:
- N_OUT=2, N_IN=4; start; acts 1,2,3,4; w0=1, w1=-1 every beat → out_valid 1 cycle after beat 4; p0=10, p1=0xFFFFFFF6.
- Same stimulus with in_valid toggling 1,0,0,1,1,0,1 → identical result; out_valid only after the 4th accepted beat.
- out_ready held low 5 cycles in DONE → p_out and out_valid stable; ready=1 → IDLE next cycle, busy=0.
- start after 2 beats (acts 5,5; w=1), then 4 beats of act=1, w=2 → p0=8; the prior partial sum is discarded.
- stop mid-ACCUM, then rst asserted asynchronously mid-beat → in_ready=0 and out_valid=0 immediately; p_out=0 after rst.
- IN_W=ACC_W=32, N_IN=1, act=0x00010000, w=0x00010000 → without macro p0=0; with MAC_LAYER_SAT_EN p0=0x7FFFFFFF and sat_flag[0]=1.
